// File: rtl/rc_search.sv
// rc_search: successive linear or binary search for the smallest x with x*y >= th
// against an external combinational RC block.
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   soc, eoc           - start of conversion in, end of conversion / idle out
//   mode               - 0 linear scan, 1 binary search
//   th                 - threshold for the x*y product
//   x, y               - candidate to the RC and its response
//   out, found, iters  - {x,y} of the last test, pass flag, number of tests
module rc_search #(
   parameter int N      = 8,
   parameter int M      = 8,
   parameter int SETTLE = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           soc,
   output logic           eoc,
   input  logic           mode,
   input  logic [N+M-1:0] th,
   output logic [N-1:0]   x,
   input  logic [M-1:0]   y,
   output logic [N+M-1:0] out,
   output logic           found,
   output logic [N:0]     iters
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);
   localparam logic [N-1:0] XMAX = '1;

   typedef enum logic [1:0] {IDLE, WAIT, TEST, DONE} state_t;

   state_t         state_q;
   logic [N-1:0]   x_q;
   logic [N-1:0]   lo_q;
   logic [N-1:0]   hi_q;
   logic [N:0]     cnt_q;
   logic [SW-1:0]  cyc_q;
   logic           mode_q;
   logic [N+M-1:0] th_q;
   logic [N+M-1:0] out_q;
   logic           found_q;
   logic [N:0]     iters_q;
   logic           eoc_q;

   logic [N+M-1:0] prod;
   logic           pass;
   logic [N-1:0]   lo_d;
   logic [N-1:0]   hi_d;
   logic [N:0]     cnt_d;
   logic           last_d;

   function automatic logic [N-1:0] mid(input logic [N-1:0] lo,
                                        input logic [N-1:0] hi);
      return lo + ((hi - lo) >> 1);
   endfunction

   // Both operands widened first so the product keeps every bit.
   assign prod   = (N+M)'(x_q) * (N+M)'(y);
   assign pass   = (prod >= th_q);
   assign lo_d   = pass ? lo_q : x_q + 1'b1;
   assign hi_d   = pass ? x_q : hi_q;
   assign cnt_d  = cnt_q + 1'b1;
   // Binary search ends on the test made with lo==hi.
   assign last_d = mode_q ? (lo_q == hi_q) : (pass || x_q == XMAX);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         lo_q    <= '0;
         hi_q    <= XMAX;
         cnt_q   <= '0;
         cyc_q   <= '0;
         mode_q  <= 1'b0;
         th_q    <= '0;
         out_q   <= '0;
         found_q <= 1'b0;
         iters_q <= '0;
         eoc_q   <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               eoc_q <= 1'b1;
               if (soc) begin
                  mode_q  <= mode;
                  th_q    <= th;
                  x_q     <= '0;
                  lo_q    <= '0;
                  hi_q    <= XMAX;
                  cnt_q   <= '0;
                  eoc_q   <= 1'b0;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (!soc) begin
                  cyc_q   <= '0;
                  x_q     <= mode_q ? mid(lo_q, hi_q) : '0;
                  state_q <= TEST;
               end
            end
            TEST: begin
               if (cyc_q != SLAST) begin
                  cyc_q <= cyc_q + 1'b1;
               end else begin
                  cyc_q <= '0;
                  cnt_q <= cnt_d;
                  if (last_d) begin
                     out_q   <= {x_q, y};
                     found_q <= pass;
                     iters_q <= cnt_d;
                     eoc_q   <= 1'b1;
                     state_q <= DONE;
                  end else if (mode_q) begin
                     lo_q <= lo_d;
                     hi_q <= hi_d;
                     x_q  <= mid(lo_d, hi_d);
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign eoc   = eoc_q;
   assign x     = x_q;
   assign out   = out_q;
   assign found = found_q;
   assign iters = iters_q;

endmodule

// File: tb/tb_rc_search.sv
// tb_rc_search: scoreboard bench for rc_search with directed vectors.
// Stimulus pushes expected results; a negedge monitor checks on each eoc rise.
module tb_rc_search;

   localparam int N = 8;
   localparam int M = 8;

   typedef struct {
      logic         found;
      logic [15:0]  out;
      logic [8:0]   iters;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         soc   = 1'b0;
   logic         mode  = 1'b0;
   logic [15:0]  th    = '0;
   logic [7:0]   y     = '0;
   logic         eoc;
   logic [7:0]   x;
   logic [15:0]  out;
   logic         found;
   logic [8:0]   iters;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   exp_t e;
   logic prev_eoc = 1'b1;

   rc_search #(.N(N), .M(M), .SETTLE(1)) dut (
      .clock (clock),
      .reset (reset),
      .soc   (soc),
      .eoc   (eoc),
      .mode  (mode),
      .th    (th),
      .x     (x),
      .y     (y),
      .out   (out),
      .found (found),
      .iters (iters)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && eoc === 1'b1 && prev_eoc === 1'b0) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_eoc: got rise expected none");
         end else begin
            e = sb.pop_front();
            chk("found", 32'(found), 32'(e.found));
            chk("out", 32'(out), 32'(e.out));
            chk("iters", 32'(iters), 32'(e.iters));
            chk("x_final", 32'(x), 32'(e.out[15:8]));
         end
      end
      prev_eoc = eoc;
   end

   task automatic wait_done(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 2000) begin
         @(negedge clock);
         k++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no eoc expected eoc rise", nm);
         sb.delete();
      end
      @(negedge clock);
   endtask

   task automatic conv(input string nm, input logic m, input logic [15:0] t,
                       input logic [7:0] yy, input logic ef,
                       input logic [15:0] eo, input logic [8:0] ei);
      sb.push_back('{ef, eo, ei});
      @(negedge clock);
      mode = m;
      th   = t;
      y    = yy;
      soc  = 1'b1;
      @(negedge clock);
      soc = 1'b0;
      wait_done(nm);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_eoc", 32'(eoc), 32'd1);
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_found", 32'(found), 32'd0);
      chk("rst_iters", 32'(iters), 32'd0);
      reset = 1'b0;

      conv("lin_abba", 1'b0, 16'hABBA, 8'hFF, 1'b1, 16'hADFF, 9'd174);
      conv("bin_abba", 1'b1, 16'hABBA, 8'hFF, 1'b1, 16'hADFF, 9'd9);
      conv("lin_nf", 1'b0, 16'h0001, 8'h00, 1'b0, 16'hFF00, 9'd256);
      conv("bin_nf", 1'b1, 16'h0001, 8'h00, 1'b0, 16'hFF00, 9'd9);
      conv("lin_th0", 1'b0, 16'h0000, 8'h3C, 1'b1, 16'h003C, 9'd1);

      // soc held high for 10 cycles
      sb.push_back('{1'b1, 16'h0055, 9'd1});
      @(negedge clock);
      mode = 1'b0;
      th   = 16'h0000;
      y    = 8'h55;
      soc  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         chk("hold_eoc", 32'(eoc), 32'd0);
         chk("hold_x", 32'(x), 32'd0);
      end
      chk("hold_pending", 32'(sb.size()), 32'd1);
      @(negedge clock);
      soc = 1'b0;
      wait_done("hold");

      // reset in the middle of a linear search
      @(negedge clock);
      mode = 1'b0;
      th   = 16'hABBA;
      y    = 8'hFF;
      soc  = 1'b1;
      @(negedge clock);
      soc = 1'b0;
      repeat (20) @(negedge clock);
      chk("mid_busy", 32'(eoc), 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("mrst_eoc", 32'(eoc), 32'd1);
      chk("mrst_x", 32'(x), 32'd0);
      chk("mrst_out", 32'(out), 32'd0);
      chk("mrst_found", 32'(found), 32'd0);
      chk("mrst_iters", 32'(iters), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      conv("fresh", 1'b1, 16'hABBA, 8'hFF, 1'b1, 16'hADFF, 9'd9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rc_search.md
RC_SEARCH -- requirements
Module: rc_search

Interface
REQ-001 SHALL have parameter N, default 8, width of candidate x.
REQ-002 SHALL have parameter M, default 8, width of RC response y.
REQ-003 SHALL have parameter SETTLE, default 1 (minimum 1), number of clock cycles the external RC needs after x changes.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port soc, input, 1, start of conversion.
REQ-007 SHALL have port eoc, output, 1, end of conversion; 1 when idle or result valid.
REQ-008 SHALL have port mode, input, 1, search mode: 0 linear, 1 binary.
REQ-009 SHALL have port th, input, N+M, threshold.
REQ-010 SHALL have port x, output, N, registered candidate driven to the external RC.
REQ-011 SHALL have port y, input, M, RC response to x.
REQ-012 SHALL have port out, output, N+M, result {x,y} of the last test.
REQ-013 SHALL have port found, output, 1, 1 if the search met the threshold.
REQ-014 SHALL have port iters, output, N+1, number of candidates tested.

Function
REQ-015 SHALL define pass = (x*y >= th), using an unsigned N+M-bit product and no truncation.
REQ-016 SHALL implement states IDLE, WAIT, TEST and DONE.
REQ-017 IDLE SHALL hold eoc=1; on soc=1 it latches mode and th, loads x=0, lo=0, hi=2^N-1 and iteration count 0, and moves to WAIT.
REQ-018 WAIT SHALL drive eoc=0 and stay in WAIT while soc=1; on soc=0 it moves to TEST.
REQ-019 TEST SHALL hold x stable for SETTLE cycles, then sample y and evaluate pass on the final cycle; each evaluation increments the count.
REQ-020 In linear mode, x SHALL start at 0.
REQ-021 Linear mode: on pass, the block SHALL go to DONE with found=1.
REQ-022 Linear mode: on fail with x=2^N-1, the block SHALL go to DONE with found=0, with no wrap to 0.
REQ-023 Linear mode: on any other fail, x SHALL increment by 1 and TEST SHALL restart.
REQ-024 In binary mode with lo<hi, x SHALL equal lo+((hi-lo)>>1).
REQ-025 Binary mode with lo<hi: on pass hi SHALL become x, on fail lo SHALL become x+1, and TEST SHALL repeat.
REQ-026 Binary mode: when lo=hi, x SHALL be set to lo for one final TEST; that result alone sets found before DONE.
REQ-027 Binary mode SHALL always take exactly N+1 tests.
REQ-028 On entry to DONE, out, found and iters SHALL register {x,y}, pass and the count in the same edge.
REQ-029 eoc SHALL rise at the DONE-entry edge and the block SHALL return to IDLE on the next edge; the result SHALL hold until the next conversion completes.
REQ-030 out, found and iters SHALL change only on DONE entry or reset.
REQ-031 soc=1 while busy in TEST or DONE SHALL be ignored.
REQ-032 x SHALL keep its final value while idle.
REQ-033 y SHALL be treated as combinational from x, with no requirement beyond SETTLE.

Reset
REQ-034 At a clock edge with reset=1, the block SHALL enter IDLE with eoc=1, x=0, out=0, found=0, iters=0, lo=0 and hi=2^N-1.
REQ-035 Reset SHALL have priority over soc and all transitions, including a reset mid-search.
REQ-036 Outputs SHALL be undefined before the first reset edge; there SHALL be no asynchronous action.

Verification
REQ-037 Bench SHALL cover: N=M=8, SETTLE=1, th=0xABBA, y=0xFF constant, mode=0, soc pulse -> found=1, out=0xADFF, iters=174, eoc rises.
REQ-038 Bench SHALL cover: same with mode=1 -> found=1, out=0xADFF, iters=9.
REQ-039 Bench SHALL cover: y=0x00, th=1, mode 0 and mode 1 -> found=0, out=0xFF00, iters=256 (linear) and 9 (binary).
REQ-040 Bench SHALL cover: th=0, mode=0 -> found=1, out={0x00,y}, iters=1.
REQ-041 Bench SHALL cover: soc held high 10 cycles -> eoc=0 from the edge after the first soc=1, x stays 0, search starts only after soc falls.
REQ-042 Bench SHALL cover: reset asserted mid-TEST -> next edge eoc=1, x=0, out=0, found=0, iters=0; a fresh soc then completes normally.
